// File: rtl/ling_add_if.sv
// ling_add_if: operand/result handshake bundle for ling_add_pipe.
// When LING_ADD_OVF_EN is defined the bundle also carries the ovf flag.
interface ling_add_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
`ifdef LING_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, s
`ifdef LING_ADD_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, s
`ifdef LING_ADD_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/ling_add_pipe.sv
// ling_add_pipe: pipelined Ling adder/subtractor. The operand width is cut
// into STAGES segments of SEG bits; stage k adds segment k (LSB first) and
// hands its carry to stage k+1. Valid/ready handshake on both sides with a
// bubble-collapsing pipeline.
// Build option: LING_ADD_OVF_EN adds the registered signed-overflow output ovf.
module ling_add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    ling_add_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_cy;
    logic [STAGES-1:0] nxt_cy;
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  xo_q    [STAGES];
    logic [WIDTH-1:0]  yo_q    [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  src_x   [STAGES];
    logic [WIDTH-1:0]  src_y   [STAGES];
    logic [WIDTH-1:0]  nxt_sum [STAGES];
    logic [SEG:0]      seg_r   [STAGES];

    // One SEG-bit Ling segment. h is the pseudo-carry; the real carry into
    // bit i is t[i-1] & h[i], with t[-1] taken as 1 so h[0] is the seed carry.
    // Returns {carry_out, sum}.
    function automatic logic [SEG:0] ling_seg(input logic [SEG-1:0] a,
                                              input logic [SEG-1:0] b,
                                              input logic           c0);
        logic [SEG-1:0] g;
        logic [SEG-1:0] t;
        logic [SEG-1:0] tprev;
        logic [SEG-1:0] c;
        logic [SEG:0]   h;
        g        = a & b;
        t        = a | b;
        tprev    = t << 1;
        tprev[0] = 1'b1;
        h        = '0;
        c        = '0;
        h[0]     = c0;
        for (int i = 0; i < SEG; i++) begin
            c[i]   = tprev[i] & h[i];
            h[i+1] = g[i] | (tprev[i] & h[i]);
        end
        return {t[SEG-1] & h[SEG], a ^ b ^ c};
    endfunction

    // Stage sources (ports for stage 0, previous register otherwise) and segment sums
    always_comb begin
        src_vld = '0;
        src_cy  = '0;
        nxt_cy  = '0;
        src_sum = '{default: '0};
        src_x   = '{default: '0};
        src_y   = '{default: '0};
        nxt_sum = '{default: '0};
        seg_r   = '{default: '0};
        src_vld[0] = bus.in_valid;
        src_cy[0]  = bus.cin;
        src_x[0]   = bus.x;
        src_y[0]   = bus.sub ? ~bus.y : bus.y;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_x[k]   = xo_q[k-1];
            src_y[k]   = yo_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_r[k]                 = ling_seg(src_x[k][k*SEG +: SEG],
                                                src_y[k][k*SEG +: SEG], src_cy[k]);
            nxt_sum[k]               = src_sum[k];
            nxt_sum[k][k*SEG +: SEG] = seg_r[k][SEG-1:0];
            nxt_cy[k]                = seg_r[k][SEG];
        end
    end

    // Stage k may load when it is empty or its contents move on this cycle
    always_comb begin
        rdy           = '0;
        rdy[STAGES-1] = ~vld_q[STAGES-1] | bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            rdy[k] = ~vld_q[k] | rdy[k+1];
        end
    end

    // Pipeline registers; data only loads with a valid beat so s holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                xo_q[k]  <= '0;
                yo_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        sum_q[k] <= nxt_sum[k];
                        cy_q[k]  <= nxt_cy[k];
                        xo_q[k]  <= src_x[k];
                        yo_q[k]  <= src_y[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.s         = {cy_q[STAGES-1], sum_q[STAGES-1]};

`ifdef LING_ADD_OVF_EN
    logic ovf_q;
    logic nxt_ovf;

    // Carry into the MSB is recovered from the MSB sum bit; overflow when it differs from carry out
    assign nxt_ovf = nxt_cy[STAGES-1] ^ src_x[STAGES-1][WIDTH-1]
                   ^ src_y[STAGES-1][WIDTH-1] ^ nxt_sum[STAGES-1][WIDTH-1];

    // Overflow flag travels with the result in the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (rdy[STAGES-1] && src_vld[STAGES-1]) begin
            ovf_q <= nxt_ovf;
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ling_add_pipe.sv
// tb_ling_add_pipe: directed vectors and corner sequences on a 32/2 instance,
// plus randomized traffic on several WIDTH/STAGES instances against an
// arithmetic reference model.
module tb_ling_add_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ling_add_if #(.WIDTH(32)) bus ();
    ling_add_pipe #(.WIDTH(32), .STAGES(2)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference: add is plain (w+1)-bit sum; sub is x - y - !cin with s[w] = no borrow
    function automatic logic [64:0] ref_add(input int w, input logic [63:0] xa,
                                            input logic [63:0] ya, input logic c,
                                            input logic sb);
        logic [65:0] one;
        logic [65:0] mask;
        logic [65:0] xv;
        logic [65:0] yv;
        logic [65:0] amt;
        logic [65:0] r;
        one  = 66'd1;
        mask = (one << w) - one;
        xv   = {2'b00, xa} & mask;
        yv   = {2'b00, ya} & mask;
        if (!sb) begin
            r = xv + yv + {65'd0, c};
        end else begin
            amt = yv + (c ? 66'd0 : 66'd1);
            r   = ((xv - amt) & mask) | ((xv >= amt) ? (one << w) : 66'd0);
        end
        return r[64:0];
    endfunction

`ifdef LING_ADD_OVF_EN
    // Reference: signed result of x +/- y with carry/borrow falls outside w-bit range
    function automatic logic ref_ovf(input int w, input logic [63:0] xa,
                                     input logic [63:0] ya, input logic c,
                                     input logic sb);
        logic signed [67:0] one;
        logic signed [67:0] sx;
        logic signed [67:0] sy;
        logic signed [67:0] r;
        one = 68'sd1;
        sx  = $signed({4'b0, xa}) & ((one <<< w) - one);
        sy  = $signed({4'b0, ya}) & ((one <<< w) - one);
        if (xa[w-1]) sx = sx - (one <<< w);
        if (ya[w-1]) sy = sy - (one <<< w);
        r = sb ? (sx - sy - (c ? 68'sd0 : 68'sd1)) : (sx + sy + (c ? 68'sd1 : 68'sd0));
        return (r > (one <<< (w - 1)) - one) || (r < -(one <<< (w - 1)));
    endfunction
`endif

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        cin;
        logic        sub;
        logic [32:0] s;
        logic        ovf;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    // Randomized instances: {WIDTH, STAGES} = {8,1} {32,2} {64,4} {48,3}
    localparam int NBEAT = 2500;
    for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
        localparam int W = (gi == 0) ? 8 : (gi == 1) ? 32 : (gi == 2) ? 64 : 48;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 3;

        logic rrst;
        bit   done;
        logic [64:0] expq [$];
        logic        ovfq [$];

        ling_add_if #(.WIDTH(W)) rbus ();
        ling_add_pipe #(.WIDTH(W), .STAGES(S)) u_rdut (.clk(clk), .rst(rrst), .bus(rbus));

        initial begin : p_rnd
            int          sent;
            int          got;
            int          cyc;
            int          sel;
            bit          stalled;
            logic [W:0]  hold_s;
            logic [63:0] xr;
            logic [63:0] yr;
            logic [64:0] e;
            logic        eo;
            done           = 1'b0;
            rrst           = 1'b1;
            rbus.in_valid  = 1'b0;
            rbus.x         = '0;
            rbus.y         = '0;
            rbus.cin       = 1'b0;
            rbus.sub       = 1'b0;
            rbus.out_ready = 1'b0;
            sent    = 0;
            got     = 0;
            cyc     = 0;
            stalled = 1'b0;
            hold_s  = '0;
            repeat (2) @(negedge clk);
            rrst = 1'b0;
            while (got < NBEAT && cyc < NBEAT * 8) begin
                @(negedge clk);
                cyc++;
                xr  = {$urandom(), $urandom()};
                yr  = {$urandom(), $urandom()};
                sel = $urandom_range(0, 7);
                if (sel == 0) xr = '1;
                if (sel == 1) yr = '1;
                if (sel == 2) yr = 64'd1;
                rbus.in_valid  = (sent < NBEAT) && ($urandom_range(0, 3) != 0);
                rbus.x         = xr[W-1:0];
                rbus.y         = yr[W-1:0];
                rbus.cin       = 1'($urandom_range(0, 1));
                rbus.sub       = 1'($urandom_range(0, 1));
                rbus.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (stalled) begin
                    checks++;
                    if (!rbus.out_valid || rbus.s !== hold_s) begin
                        errors++;
                        $display("FAIL rnd%0d_stall_hold: got v=%b s=%h expected v=1 s=%h",
                                 gi, rbus.out_valid, rbus.s, hold_s);
                    end
                end
                stalled = rbus.out_valid && !rbus.out_ready;
                hold_s  = rbus.s;
                if (rbus.out_valid && rbus.out_ready) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL rnd%0d_extra_beat: got s=%h expected no beat", gi, rbus.s);
                    end else begin
                        e = expq.pop_front();
                        if (rbus.s !== e[W:0]) begin
                            errors++;
                            $display("FAIL rnd%0d_sum: got %h expected %h", gi, rbus.s, e[W:0]);
                        end
                        eo = ovfq.pop_front();
`ifdef LING_ADD_OVF_EN
                        checks++;
                        if (rbus.ovf !== eo) begin
                            errors++;
                            $display("FAIL rnd%0d_ovf: got %b expected %b", gi, rbus.ovf, eo);
                        end
`endif
                    end
                    got++;
                end
                if (rbus.in_valid && rbus.in_ready) begin
                    expq.push_back(ref_add(W, xr, yr, rbus.cin, rbus.sub));
`ifdef LING_ADD_OVF_EN
                    ovfq.push_back(ref_ovf(W, xr, yr, rbus.cin, rbus.sub));
`else
                    ovfq.push_back(1'b0);
`endif
                    sent++;
                end
            end
            checks++;
            if (got != NBEAT) begin
                errors++;
                $display("FAIL rnd%0d_beats: got %0d expected %0d", gi, got, NBEAT);
            end
            rbus.in_valid = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int          lat;
        bit          seen;
        bit          stalled;
        bit          dropped;
        bit          stale;
        int          sent;
        int          got;
        logic [32:0] hold_s;
        logic [64:0] exp_q [$];

        vec[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0};
        vec[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 33'h0_FFFF_FFFE, 1'b0};
        vec[2]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 33'h1_0000_0002, 1'b0};
        vec[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 33'h0_0000_0001, 1'b0};
        vec[4]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33'h1_0000_0000, 1'b1};
        vec[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 33'h0_FFFF_FFFF, 1'b0};
        vec[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 33'h1_0000_0000, 1'b0};
        vec[7]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 33'h0_ACF1_3568, 1'b0};
        vec[8]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1};
        vec[9]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 33'h1_7FFF_FFFF, 1'b1};
        vec[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_FFFF_FFFF, 1'b0};
        vec[11] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0001_0000, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_s", bus.s, 0);
        chk("reset_in_ready", bus.in_ready, 1);

        // single beats: result and latency
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.x         = vec[i].x;
            bus.y         = vec[i].y;
            bus.cin       = vec[i].cin;
            bus.sub       = vec[i].sub;
            bus.out_ready = 1'b1;
            #1;
            chk("vec_in_ready", bus.in_ready, 1);
            @(posedge clk);
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 8) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                #1;
                lat++;
                seen = bus.out_valid;
            end
            chk("vec_latency", lat, 2);
            chk("vec_s", bus.s, vec[i].s);
`ifdef LING_ADD_OVF_EN
            chk("vec_ovf", bus.ovf, vec[i].ovf);
`endif
        end

        // four back-to-back beats with a three-cycle output stall
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        dropped = 1'b0;
        hold_s  = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < 4);
            bus.x         = 32'h1000_0000 * (sent + 1) + sent;
            bus.y         = 32'hF000_0001 + sent;
            bus.cin       = sent[0];
            bus.sub       = sent[1];
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (stalled) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_s", bus.s, hold_s);
            end
            if (!bus.in_ready) dropped = 1'b1;
            stalled = bus.out_valid && !bus.out_ready;
            hold_s  = bus.s;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("stall_extra_beat", bus.s, 65'h1_FFFF_FFFF_FFFF_FFFF);
                else chk("stall_order", bus.s, exp_q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_add(32, bus.x, bus.y, bus.cin, bus.sub));
                sent++;
            end
        end
        chk("stall_count", got, 4);
        chk("stall_in_ready_drop", dropped, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("stall_no_dup", bus.out_valid, 0);

        // reset with two beats in flight
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.x         = 32'd1;
        bus.y         = 32'd2;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.x = 32'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("pre_reset_full", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_reset_out_valid", bus.out_valid, 0);
        chk("mid_reset_s", bus.s, 0);
        repeat (2) @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", bus.in_ready, 1);
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) stale = 1'b1;
        end
        chk("post_reset_no_stale", stale, 0);

        // wait for the randomized instances, bounded
        for (int c = 0; c < 30000; c++) begin
            if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done) break;
            @(posedge clk);
        end
        chk("random_done", {g_rnd[0].done, g_rnd[1].done, g_rnd[2].done, g_rnd[3].done}, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ling_add_pipe.md
LING_ADD_PIPE -- requirements
Module: ling_add_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal 4..64.
REQ-002 Parameter: STAGES, default 2, pipeline depth; legal 1..4; WIDTH SHALL be divisible by STAGES.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand beat offered.
REQ-006 Port: in_ready  output  1  block accepts beat this cycle.
REQ-007 Port: x  input  WIDTH  operand A.
REQ-008 Port: y  input  WIDTH  operand B.
REQ-009 Port: cin  input  1  carry-in.
REQ-010 Port: sub  input  1  1 = x - y - ~cin (y inverted, cin as borrow-complement), 0 = x + y + cin.
REQ-011 Port: out_valid  output  1  result beat available.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: s  output  WIDTH+1  result; bit WIDTH = carry-out of the final segment.

Function
REQ-014 Width split into STAGES segments of SEG = WIDTH/STAGES bits; stage k computes segment k (LSB first) using Ling pseudo-carry recurrence h[i+1] = g[i] | t[i]&h[i], real carry = t&h, seeded by carry from stage k-1 (stage 0 seeded by cin).
REQ-015 Per stage registers: valid bit, partial sum of completed segments, carry, delayed upper operand bits not yet summed; operand bits SHALL be pre-inverted for sub at stage-0 input.
REQ-016 Latency: accepted beat appears on s/out_valid exactly STAGES cycles later when no stall.
REQ-017 Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
REQ-018 Stage k advances when stage k+1 empty or advancing; last stage advances when out_ready or empty (bubble-collapsing).
REQ-019 in_ready = stage 0 empty or stage 0 advancing; combinational from out_ready allowed, no combinational path from in_valid to in_ready.
REQ-020 While out_valid & ~out_ready, s and out_valid SHALL hold stable.
REQ-021 Throughput: one beat per cycle with out_ready held high.
REQ-022 Simultaneous input and output transfer on a full pipe SHALL lose and duplicate no beat.
REQ-023 Arithmetic modulo 2^(WIDTH+1): s = {cout, sum}; e.g. all-ones + 1 wraps sum to 0 with cout = 1.
REQ-024 Sub mode: s[WIDTH] = 1 means no borrow (x >= y + ~cin unsigned).
REQ-025 Beats SHALL exit in acceptance order; sub flag travels with its beat.

Reset
REQ-026 rst high: all valid bits, data and carry registers to 0 immediately; out_valid = 0, s = 0, in_ready = 1 on the first cycle after release.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; no beat emerges after release unless newly accepted.

Configuration
REQ-028 Macro LING_ADD_OVF_EN defined: extra output ovf, 1 bit, = signed two's-complement overflow of the beat on s (carry into MSB xor carry out), registered with s, reset 0, held under stall.
REQ-029 Macro LING_ADD_OVF_EN undefined: no ovf port, no associated logic; all other behaviour identical.

Verification
REQ-030 WIDTH=32, STAGES=2: x=0xFFFFFFFF, y=1, cin=0, sub=0 -> s=0x1_00000000 exactly 2 cycles after acceptance.
REQ-031 Sub: x=5, y=7, cin=1, sub=1 -> s = {0, 0xFFFFFFFE}; x=7, y=5 -> s = {1, 0x00000002}.
REQ-032 Stall: 4 back-to-back beats, out_ready low 3 cycles mid-stream -> in_ready drops when full, s stable during stall, 4 results in order, none lost or duplicated.
REQ-033 Reset mid-stream: rst asserted with 2 beats in flight -> out_valid 0 immediately, no stale result after release.
REQ-034 Random 10k beats over STAGES 1..4, WIDTH 8/32/64, random valid/ready -> every s matches reference {cout,sum}; with LING_ADD_OVF_EN, 0x7FFFFFFF+1 -> ovf=1.
